tt_um_ccjiaa_count_monitor: RTL and testbench

//   Receive-side checker for the 8-bit load/increment counter bus. Samples the

---
 rtl/tt_um_ccjiaa_count_monitor.sv | 143 ++++++++++++++
 tb/tb_tt_um_ccjiaa_count_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_ccjiaa_count_monitor.sv
// Receive-side checker for an 8-bit load/increment counter bus.
// Predicts the next count value (increment, or load when load_val is nonzero) and
// locks after LOCK_CNT consecutive correct samples. Once locked, every deviation
// raises err_pulse and bumps a saturating error counter.
// Optional build macro CCJIAA_MON_STICKY_EN: FAULT is held until clr_err is asserted.
module tt_um_ccjiaa_count_monitor #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] last_good
);

  // Match counter needs at least one bit even when LOCK_CNT == 1.
  localparam int unsigned MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [MW-1:0] LastMatch = MW'(LOCK_CNT - 1);

  typedef enum logic [1:0] {StIdle, StAcquire, StLocked, StFault} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             exp_vld_q, exp_vld_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [WIDTH-1:0] last_good_q, last_good_d;
  logic             err_inc;
  logic             match;

  assign match = exp_vld_q && (count_in == exp_q);

  // Next-state, prediction and pulse generation.
  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    exp_vld_d    = exp_vld_q;
    match_cnt_d  = match_cnt_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    last_good_d  = last_good_q;
    err_inc      = 1'b0;

    if (!enable) begin
      state_d     = StIdle;
      exp_vld_d   = 1'b0;
      match_cnt_d = '0;
    end else begin
      // A zero load value cannot be told apart from "no load".
      exp_d     = (load_val != '0) ? load_val : count_in + WIDTH'(1);
      exp_vld_d = 1'b1;
      unique case (state_q)
        StIdle: begin
          state_d     = StAcquire;
          match_cnt_d = '0;
        end
        StAcquire: begin
          if (match) begin
            if (match_cnt_q == LastMatch) begin
              state_d     = StLocked;
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + MW'(1);
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        StLocked: begin
          if (match) begin
            last_good_d  = count_in;
            wrap_pulse_d = (count_in == '0);
          end else begin
            state_d     = StFault;
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
          end
        end
        StFault: begin
`ifdef CCJIAA_MON_STICKY_EN
          if (clr_err) begin
            state_d     = StAcquire;
            match_cnt_d = '0;
          end
`else
          state_d     = StAcquire;
          match_cnt_d = '0;
`endif
        end
        default: state_d = StIdle;
      endcase
    end

    // Clear wins over a same-cycle increment; increment saturates at all-ones.
    if (clr_err) begin
      err_count_d = '0;
    end else if (err_inc && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      exp_q        <= '0;
      exp_vld_q    <= 1'b0;
      match_cnt_q  <= '0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_count_q  <= '0;
      last_good_q  <= '0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      exp_vld_q    <= exp_vld_d;
      match_cnt_q  <= match_cnt_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_count_q  <= err_count_d;
      last_good_q  <= last_good_d;
    end
  end

  assign locked     = (state_q == StLocked);
  assign err_pulse  = err_pulse_q;
  assign wrap_pulse = wrap_pulse_q;
  assign err_count  = err_count_q;
  assign last_good  = last_good_q;

endmodule

// File: tb/tb_tt_um_ccjiaa_count_monitor.sv
// Scoreboard bench for tt_um_ccjiaa_count_monitor (default, non-sticky build).
// The driver pushes the hand-computed response expected after each clock edge;
// a monitor pops and compares on the following falling edge.
module tb_tt_um_ccjiaa_count_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] count_in = 8'h00;
  logic [7:0] load_val = 8'h00;
  logic       locked, err_pulse, wrap_pulse;
  logic [7:0] err_count, last_good;

  typedef struct packed {
    logic       lk;
    logic       ep;
    logic       wp;
    logic [7:0] ec;
    logic       chk_lg;
    logic [7:0] lg;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_step = 0;
  logic [7:0] ec_m = 8'h00;
  logic [7:0] v;

  always #5 clk = ~clk;

  tt_um_ccjiaa_count_monitor #(
    .WIDTH   (8),
    .LOCK_CNT(4),
    .ERR_W   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .count_in  (count_in),
    .load_val  (load_val),
    .clr_err   (clr_err),
    .locked    (locked),
    .err_pulse (err_pulse),
    .wrap_pulse(wrap_pulse),
    .err_count (err_count),
    .last_good (last_good)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Drive one sample, clock it in, and queue the response expected after the edge.
  task automatic step(input logic en, input logic [7:0] cnt, input logic [7:0] ld,
                      input logic clr, input logic lk, input logic ep, input logic wp,
                      input logic [7:0] ec, input logic chk_lg, input logic [7:0] lg);
    exp_t e;
    enable   = en;
    count_in = cnt;
    load_val = ld;
    clr_err  = clr;
    e = '{lk: lk, ep: ep, wp: wp, ec: ec, chk_lg: chk_lg, lg: lg};
    @(posedge clk);
    sb_q.push_back(e);
    #1;
  endtask

  // Acquisition-phase sample (last_good not examined).
  task automatic acq(input logic [7:0] cnt, input logic lk);
    step(1'b1, cnt, 8'h00, 1'b0, lk, 1'b0, 1'b0, ec_m, 1'b0, 8'h00);
  endtask

  // Locked, matching sample: last_good must follow it.
  task automatic trk(input logic [7:0] cnt, input logic [7:0] ld);
    step(1'b1, cnt, ld, 1'b0, 1'b1, 1'b0, 1'b0, ec_m, 1'b1, cnt);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err_pulse"}, err_pulse, 0);
    chk({tag, "_wrap_pulse"}, wrap_pulse, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_last_good"}, last_good, 0);
  endtask

  // Monitor: the DUT presents a response every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_step++;
        chk($sformatf("locked@%0d", n_step), locked, e.lk);
        chk($sformatf("err_pulse@%0d", n_step), err_pulse, e.ep);
        chk($sformatf("wrap_pulse@%0d", n_step), wrap_pulse, e.wp);
        chk($sformatf("err_count@%0d", n_step), err_count, e.ec);
        if (e.chk_lg) chk($sformatf("last_good@%0d", n_step), last_good, e.lg);
      end
    end
  end

  initial begin
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Lock on a plain incrementing stream, then track up to 0x10.
    acq(8'h00, 1'b0);
    acq(8'h01, 1'b0);
    acq(8'h02, 1'b0);
    acq(8'h03, 1'b0);
    acq(8'h04, 1'b1);
    for (int i = 5; i <= 16; i++) trk(8'(i), 8'h00);

    // Inject 0x20 where 0x11 is due; FAULT for one cycle, then relock.
    ec_m = 8'h01;
    step(1'b1, 8'h20, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, ec_m, 1'b1, 8'h10);
    acq(8'h21, 1'b0);
    acq(8'h22, 1'b0);
    acq(8'h23, 1'b0);
    acq(8'h24, 1'b0);
    acq(8'h25, 1'b1);

    // Load to 0xFE, then wrap 0xFF -> 0x00.
    trk(8'h26, 8'hFE);
    trk(8'hFE, 8'h00);
    trk(8'hFF, 8'h00);
    step(1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, ec_m, 1'b1, 8'h00);
    trk(8'h01, 8'h00);

    // Load 0x80 while locked at 0x05.
    trk(8'h02, 8'h00);
    trk(8'h03, 8'h00);
    trk(8'h04, 8'h00);
    trk(8'h05, 8'h80);
    trk(8'h80, 8'h00);
    trk(8'h81, 8'h00);

    // Disable: back to IDLE, err_count and last_good held.
    step(1'b0, 8'h82, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, ec_m, 1'b1, 8'h81);
    step(1'b0, 8'h99, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, ec_m, 1'b1, 8'h81);
    acq(8'h50, 1'b0);
    acq(8'h51, 1'b0);
    acq(8'h52, 1'b0);
    acq(8'h53, 1'b0);
    acq(8'h54, 1'b1);

    // 300 mismatches, relocking after each; count saturates at 0xFF.
    v = 8'h54;
    for (int i = 0; i < 300; i++) begin
      ec_m = (ec_m == 8'hFF) ? 8'hFF : ec_m + 8'd1;
      step(1'b1, v + 8'd2, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, ec_m, 1'b0, 8'h00);
      acq(v + 8'd3, 1'b0);
      acq(v + 8'd4, 1'b0);
      acq(v + 8'd5, 1'b0);
      acq(v + 8'd6, 1'b0);
      acq(v + 8'd7, 1'b1);
      v = v + 8'd7;
    end

    // clr_err together with a mismatch: clear wins.
    ec_m = 8'h00;
    step(1'b1, v + 8'd2, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    acq(v + 8'd3, 1'b0);
    acq(v + 8'd4, 1'b0);
    acq(v + 8'd5, 1'b0);
    acq(v + 8'd6, 1'b0);
    acq(v + 8'd7, 1'b1);
    trk(v + 8'd8, 8'h00);

    // Asynchronous reset while locked.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    acq(8'h07, 1'b0);
    acq(8'h08, 1'b0);
    acq(8'h09, 1'b0);
    acq(8'h0A, 1'b0);
    acq(8'h0B, 1'b1);
    trk(8'h0C, 8'h00);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
    #1;
    chk("sb_drain", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
